layer_sequencer: RTL
====================

// Module: layer_sequencer
// PURPOSE
//  Sequences one shared MAC/bias/activation datapath across all neurons of a dense layer.
//  Runs the one-time weight/bias fill into the channel memories, then, per req, steps neuron
//  by neuron: clear acc, N_IN MACs, bias add, activation, result write; raises ack_layer at end.
//  Sits between the network-level controller (fill/req/ack_layer) and the layer datapath.
// PARAMETERS
//  N_IN   2  inputs per neuron (>=1)
//  N_OUT  3  neurons in layer (>=1); all time-share one MAC
//  AW_I   1  width of x_sel / input counter, clog2(N_IN) (min 1)
//  AW_N   2  width of b_addr/out_idx / neuron counter, clog2(N_OUT) (min 1)
//  AW_W   3  width of w_addr, clog2(N_IN*N_OUT) (min 1)
// PORTS
//  clk        in   1     clock, all state on posedge
//  rst        in   1     asynchronous, active-low reset
//  fill       in   1     request one-time load of weights+biases
//  req        in   1     start one layer evaluation (level, held until ack_layer)
//  fill_done  out  1     sticky: weights and biases loaded
//  busy       out  1     high in any state other than IDLE/DONE
//  ack_layer  out  1     layer outputs complete; high in DONE
//  w_we       out  1     weight-memory write strobe (fill)
//  b_we       out  1     bias-memory write strobe (fill)
//  w_addr     out  AW_W  weight address = neuron*N_IN + input index (fill and MAC)
//  b_addr     out  AW_N  bias address (fill, BIAS)
//  x_sel      out  AW_I  input operand select during MAC
//  mac_clr    out  1     zero accumulator
//  mac_en     out  1     acc += (w*x)>>>4
//  bias_en    out  1     acc += b[b_addr]
//  act_en     out  1     apply activation to acc
//  out_we     out  1     write activated value to output slot out_idx
//  out_idx    out  AW_N  output slot / current neuron
// BEHAVIOUR
//  - Moore FSM; every strobe/address decoded from registered state+counters only.
//  - rst low (async): state IDLE, all counters 0, fill_done 0, all outputs 0.
//    Reset mid-fill or mid-evaluation aborts; no further strobes; fill must be repeated.
//  - States: IDLE, FILL_W, FILL_B, CLR, MAC, BIAS, ACT, WRITE, DONE.
//  - IDLE: fill & ~fill_done -> FILL_W (fill wins if req also high);
//    else req & fill_done -> CLR; req while ~fill_done ignored; fill while fill_done ignored.
//  - FILL_W: w_we=1, w_addr = 0..N_IN*N_OUT-1, one per cycle; after last -> FILL_B.
//    FILL_B: b_we=1, b_addr = 0..N_OUT-1; after last -> IDLE, fill_done<=1.
//    Fill takes exactly N_IN*N_OUT+N_OUT cycles; fill may drop after the IDLE sample.
//  - CLR (1 cyc): mac_clr=1, out_idx=n. MAC (N_IN cyc): mac_en=1, x_sel=i,
//    w_addr=n*N_IN+i, i counts 0..N_IN-1 then wraps to 0. BIAS (1): bias_en=1, b_addr=n.
//    ACT (1): act_en=1. WRITE (1): out_we=1, out_idx=n; n==N_OUT-1 -> DONE, else n++ -> CLR.
//  - Per neuron N_IN+4 cycles; req sampled at edge k -> ack_layer high from cycle
//    k+1+N_OUT*(N_IN+4). Memory/input reads complete within the issuing cycle.
//  - DONE: ack_layer=1 while req high; req low -> IDLE (ack_layer 0 next cycle), n cleared.
//  - req dropping before DONE does not abort; evaluation completes, then DONE->IDLE next cycle
//    if req still low (ack_layer one-cycle pulse).
//  - At most one of w_we,b_we,mac_clr,mac_en,bias_en,act_en,out_we high per cycle.
//  - Arithmetic stays in datapath (8-bit signed, product >>>4, wrapping); this block only counts.
// TESTING (defaults N_IN=2, N_OUT=3)
//  1 reset, fill pulse 1 cyc -> w_we 6 cyc w_addr 0..5, then b_we 3 cyc b_addr 0..2, fill_done=1
//    at cycle 10 after sample; no other strobes.
//  2 after fill, req high -> sequence CLR,MAC(0,0),MAC(0,1),BIAS,ACT,WRITE per neuron, w_addr
//    0,1 / 2,3 / 4,5, out_idx 0,1,2; ack_layer at cycle 19 after req sample; one-hot check.
//  3 req before fill_done -> no strobes, busy=0; then fill+req together -> fill runs first,
//    req still high afterwards starts evaluation.
//  4 rst low during MAC of neuron 1 -> all outputs 0 async, fill_done 0; req alone then ignored.
//  5 req held 5 cycles after ack_layer -> ack stays high; req low -> IDLE; second req
//    reproduces identical strobe trace (counters wrapped correctly).
//  6 N_IN=1,N_OUT=1 build: req -> CLR,MAC,BIAS,ACT,WRITE, ack_layer at cycle 6.

Source files
------------

// File: rtl/layer_sequencer.sv
// layer_sequencer: time-shares one MAC/bias/activation datapath across the neurons of a dense layer
// Ports: clk; rst (async, active-low); fill/req from the network controller; fill_done/busy/ack_layer status;
// w_we/b_we/w_addr/b_addr drive the weight and bias fill; x_sel/mac_clr/mac_en/bias_en/act_en/out_we/out_idx
// steer the datapath one neuron at a time. Every output is decoded from registered state and counters.
module layer_sequencer #(
  parameter int N_IN  = 2,
  parameter int N_OUT = 3,
  parameter int AW_I  = 1,
  parameter int AW_N  = 2,
  parameter int AW_W  = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fill,
  input  logic            req,
  output logic            fill_done,
  output logic            busy,
  output logic            ack_layer,
  output logic            w_we,
  output logic            b_we,
  output logic [AW_W-1:0] w_addr,
  output logic [AW_N-1:0] b_addr,
  output logic [AW_I-1:0] x_sel,
  output logic            mac_clr,
  output logic            mac_en,
  output logic            bias_en,
  output logic            act_en,
  output logic            out_we,
  output logic [AW_N-1:0] out_idx
);
  typedef enum logic [3:0] {IDLE, FILL_W, FILL_B, CLR, MAC, BIAS, ACT, WRITE, DONE} state_t;
  localparam logic [AW_W-1:0] W_LAST = AW_W'(N_IN * N_OUT - 1);
  localparam logic [AW_N-1:0] N_LAST = AW_N'(N_OUT - 1);
  localparam logic [AW_I-1:0] I_LAST = AW_I'(N_IN - 1);
  state_t state, nxt;
  logic [AW_W-1:0] wc;
  logic [AW_N-1:0] n;
  logic [AW_I-1:0] i;
  logic w_last, n_last, i_last;
  assign w_last = wc == W_LAST;
  assign n_last = n == N_LAST;
  assign i_last = i == I_LAST;
  // n doubles as the bias fill address and the neuron index; it wraps to 0 after either pass
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      wc        <= '0;
      n         <= '0;
      i         <= '0;
      fill_done <= 1'b0;
    end else begin
      state     <= nxt;
      wc        <= (state == FILL_W && !w_last) ? wc + AW_W'(1) : '0;
      i         <= (state == MAC && !i_last) ? i + AW_I'(1) : '0;
      n         <= (state == FILL_B || state == WRITE) ? (n_last ? '0 : n + AW_N'(1)) : n;
      fill_done <= fill_done | (state == FILL_B && n_last);
    end
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = (fill && !fill_done) ? FILL_W : (req && fill_done) ? CLR : IDLE;
      FILL_W:  nxt = w_last ? FILL_B : FILL_W;
      FILL_B:  nxt = n_last ? IDLE : FILL_B;
      CLR:     nxt = MAC;
      MAC:     nxt = i_last ? BIAS : MAC;
      BIAS:    nxt = ACT;
      ACT:     nxt = WRITE;
      WRITE:   nxt = n_last ? DONE : CLR;
      DONE:    nxt = req ? DONE : IDLE;
      default: nxt = IDLE;
    endcase
  end
  assign busy      = state != IDLE && state != DONE;
  assign ack_layer = state == DONE;
  assign w_we      = state == FILL_W;
  assign b_we      = state == FILL_B;
  assign mac_clr   = state == CLR;
  assign mac_en    = state == MAC;
  assign bias_en   = state == BIAS;
  assign act_en    = state == ACT;
  assign out_we    = state == WRITE;
  assign w_addr    = w_we ? wc : mac_en ? AW_W'(n) * AW_W'(N_IN) + AW_W'(i) : '0;
  assign b_addr    = (b_we || bias_en) ? n : '0;
  assign x_sel     = mac_en ? i : '0;
  assign out_idx   = (busy && !w_we && !b_we) ? n : '0;
endmodule
